// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the single-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // Index width for a given count; never below one bit so degenerate sizes still elaborate.
  function automatic int calc_aw(input int depth);
    if (depth <= 1) begin
      return 1;
    end else begin
      return $clog2(depth);
    end
  endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo NREQ.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW = calc_aw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  logic [PW-1:0] cand_s;

  // Walk rotation distances from farthest to nearest so the nearest set bit is the last write.
  always_comb begin
    any    = |req;
    idx    = {PW{1'b0}};
    cand_s = {PW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s = PW'((int'(ptr) + k) % NREQ);
      if (req[cand_s]) begin
        idx = cand_s;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ requesters.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int NREQ  = 4,
  localparam int AW = calc_aw(DEPTH),
  localparam int PW = calc_aw(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr_rd,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rvalid,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  ram_en,
  output logic                  ram_wr_rd,
  output logic [AW-1:0]         ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  input  logic [WIDTH-1:0]      ram_rdata
);

  state_t           state_r;
  state_t           next_state_s;
  logic [PW-1:0]    owner_r;
  logic [PW-1:0]    ptr_r;
  logic             pick_any_s;
  logic [PW-1:0]    pick_idx_s;
  logic             sel_wr_rd_s;
  logic [AW-1:0]    sel_addr_s;
  logic [WIDTH-1:0] sel_wdata_s;
  logic [NREQ-1:0]  gnt_r;
  logic [NREQ-1:0]  rvalid_r;
  logic [WIDTH-1:0] rdata_r;
  logic             ram_en_r;
  logic             ram_wr_rd_r;
  logic [AW-1:0]    ram_addr_r;
  logic [WIDTH-1:0] ram_wdata_r;

  function automatic logic [NREQ-1:0] to_onehot(input logic [PW-1:0] i);
    return NREQ'(1'b1) << i;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return {PW{1'b0}};
    end else begin
      return i + PW'(1'b1);
    end
  endfunction

  ram_arb_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req (req),
    .ptr (ptr_r),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // Payload of the requester that would win this arbitration.
  always_comb begin
    sel_wr_rd_s = wr_rd[pick_idx_s];
    sel_addr_s  = addr[int'(pick_idx_s) * AW +: AW];
    sel_wdata_s = wdata[int'(pick_idx_s) * WIDTH +: WIDTH];
  end

  // Next-state decode; the ISSUE exit uses the latched access type.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (ram_wr_rd_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RD_WAIT;
        end
      end
      RD_WAIT: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Owner, pointer, RAM drive and read return; RAM lines are loaded only for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r     <= {PW{1'b0}};
      ptr_r       <= {PW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      rvalid_r    <= {NREQ{1'b0}};
      rdata_r     <= {WIDTH{1'b0}};
      ram_en_r    <= 1'b0;
      ram_wr_rd_r <= 1'b0;
      ram_addr_r  <= {AW{1'b0}};
      ram_wdata_r <= {WIDTH{1'b0}};
    end else begin
      if (state_r == IDLE && pick_any_s) begin
        owner_r     <= pick_idx_s;
        gnt_r       <= to_onehot(pick_idx_s);
        ram_en_r    <= 1'b1;
        ram_wr_rd_r <= sel_wr_rd_s;
        ram_addr_r  <= sel_addr_s;
        ram_wdata_r <= sel_wdata_s;
      end else begin
        owner_r     <= owner_r;
        gnt_r       <= {NREQ{1'b0}};
        ram_en_r    <= 1'b0;
        ram_wr_rd_r <= 1'b0;
        ram_addr_r  <= {AW{1'b0}};
        ram_wdata_r <= {WIDTH{1'b0}};
      end

      if (state_r == ISSUE) begin
        ptr_r <= next_ptr(owner_r);
      end else begin
        ptr_r <= ptr_r;
      end

      if (state_r == RD_WAIT) begin
        rdata_r  <= ram_rdata;
        rvalid_r <= to_onehot(owner_r);
      end else begin
        rdata_r  <= rdata_r;
        rvalid_r <= {NREQ{1'b0}};
      end
    end
  end

  assign gnt       = gnt_r;
  assign rvalid    = rvalid_r;
  assign rdata     = rdata_r;
  assign busy      = (state_r != IDLE);
  assign ram_en    = ram_en_r;
  assign ram_wr_rd = ram_wr_rd_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port synchronous RAM (WIDTH x DEPTH, registered read data) between NREQ requesters.
- Each requester issues single-word read or write accesses with a req/gnt handshake. Read data returns on a shared bus with a per-requester valid strobe.
- Sits between client engines and the RAM instance. Owns the RAM enable, write/read, address and write-data lines.

Parameters:
- WIDTH, 8, data word width
- DEPTH, 32, RAM words; AW = $clog2(DEPTH)
- NREQ, 4, number of requesters (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  access request per requester; held with payload until gnt
- wr_rd  in  NREQ  per requester: 1 = write, 0 = read
- addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*WIDTH  flattened write data
- gnt  out  NREQ  one-hot one-cycle pulse: access accepted and issued
- rvalid  out  NREQ  one-hot one-cycle pulse: rdata valid for that requester
- rdata  out  WIDTH  registered read data, holds last read value
- busy  out  1  state != IDLE
- ram_en  out  1  RAM access strobe
- ram_wr_rd  out  1  1 = write, 0 = read
- ram_addr  out  AW  RAM address
- ram_wdata  out  WIDTH  RAM write data
- ram_rdata  in  WIDTH  RAM registered read output, valid the cycle after a read edge

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=IDLE, owner=0, ptr=0, rdata=0.
  - gnt, rvalid, busy, ram_en, ram_wr_rd, ram_addr and ram_wdata are all 0.
  - Reset overrides all other activity. An in-flight read is abandoned with no rvalid.
- FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - If any req bit is set at an edge, select the owner by round robin: the first set bit searching from index ptr upward, wrapping modulo NREQ. Register the owner and go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE (exactly one cycle):
  - ram_en=1. ram_wr_rd, ram_addr and ram_wdata are taken from the owner's inputs.
  - gnt[owner]=1.
  - At the closing edge: the RAM performs the access and ptr <= (owner+1) mod NREQ. Next state is RD_WAIT if the access is a read, otherwise IDLE.
- RD_WAIT (one cycle):
  - At the closing edge, rdata <= ram_rdata and rvalid[owner] is set for the following cycle. Go to IDLE.
- Outside ISSUE, all ram_* outputs are 0.
- gnt and rvalid are decoded from registered state and owner only, so they are glitch-free and never more than one bit set.
- Latency, with the req edge counted as edge 0:
  - gnt is high in cycle 1.
  - A write lands at edge 1; the next arbitration is at edge 2 (1 write per 2 cycles).
  - For a read, rvalid and rdata are seen in cycle 3; the next arbitration is at edge 3 (1 read per 3 cycles).
- Requester protocol:
  - Hold req, wr_rd, addr and wdata stable until gnt.
  - After gnt, the requester may drop req or present a new access; it is sampled at the next IDLE edge.
  - Once the owner is latched, the access completes even if req drops (protocol violation; not an error).
- Simultaneous requests: exactly one grant per arbitration. The most recently served requester has the lowest priority next time.
- NREQ=1: ptr is always 0 and the block degenerates to a sequencer.
- rdata is unchanged by writes and idle cycles.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE, ISSUE, RD_WAIT) and the AW computation helper.
- Sub-module ram_arb_rr_pick: purely combinational round-robin selector with inputs req[NREQ-1:0] and ptr, and outputs any and idx.
- FSM, payload mux and read return logic live in ram_arbiter.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req=4'b1111 -> gnt=0, rvalid=0, rdata=0, ram_en=0, busy=0 throughout.
- Single write then read:
  - Requester 2 writes 8'hA5 to addr 7 -> gnt[2] in cycle 1, ram_en=1, ram_wr_rd=1, ram_addr=7.
  - Requester 2 then reads addr 7 -> rvalid[2] three cycles after req, rdata=8'hA5.
- Round robin: req=4'b1111 held, all writes -> grant order 0,1,2,3,0, one gnt every 2 cycles.
- Mixed contention:
  - Requester 0 reads addr 3 (holding 8'h11) while requester 1 writes 8'h22 to addr 3 in the same cycle.
  - Requester 0 is served first -> rvalid[0] with rdata=8'h11, then gnt[1]; a subsequent read of addr 3 returns 8'h22.
- Reset mid-read: assert rst during RD_WAIT -> no rvalid pulse, rdata=0, state IDLE, ptr=0.
- Dropped req: requester 3 lowers req in the ISSUE cycle -> gnt[3] still pulses and the write to its addr still lands.
